disk_stream_ctrl: RTL and testbench
===================================

Name: disk_stream_ctrl

Overview:
- Sequencer and result buffer wrapped around disk_fsm_32bit_simple_minimal.
- Issues consecutive indices k to the disk point generator over its start/ready/done handshake and captures each (result_x, result_y) pair into a small FIFO.
- Presents the pairs downstream as a valid/ready stream tagged with k and a last flag.
- Replaces the hand-driven start/done sequencing so downstream consumers receive a continuous disk-point stream.

Parameters:
- FIFO_DEPTH, 4, result FIFO entries; power of two, >= 2.
- K_WIDTH, 32, width of the index and of count.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run_start  in  1  one-cycle pulse; begins a run; ignored unless idle.
- run_abort  in  1  one-cycle pulse; cancels the active run.
- k_start  in  K_WIDTH  first index of the run.
- count  in  K_WIDTH  number of points in the run.
- base_sel0  in  2  base selector 0 (base = sel+2); latched at run_start.
- base_sel1  in  2  base selector 1; latched at run_start.
- busy  out  1  run in progress.
- run_done  out  1  one-cycle pulse at run completion or abort completion.
- disk_start  out  1  start pulse to the disk FSM.
- disk_k  out  32  index to the disk FSM.
- disk_base_sel0  out  2  latched base_sel0.
- disk_base_sel1  out  2  latched base_sel1.
- disk_result_x  in  32  disk x result.
- disk_result_y  in  32  disk y result.
- disk_done  in  1  disk result valid.
- disk_ready  in  1  disk FSM idle.
- m_valid  out  1  stream data valid.
- m_ready  in  1  downstream accept.
- m_x  out  32  x of the head FIFO entry.
- m_y  out  32  y of the head FIFO entry.
- m_k  out  K_WIDTH  index of the head entry.
- m_last  out  1  head entry is the final point of the run.

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE. Reset mid-run discards everything with no run_done pulse.
- States: IDLE, ISSUE, WAIT, DRAIN, ABORT.
- IDLE:
  - run_start latches k_start, count and base sels; busy=1 on the next cycle.
  - count==0: go to DRAIN with nothing issued.
  - count!=0: go to ISSUE.
- ISSUE:
  - Enter WAIT when disk_ready=1 and fifo_occupancy < FIFO_DEPTH.
  - On that transition assert disk_start for exactly one cycle, with disk_k = current k.
  - disk_k and disk_base_sel* stay stable from disk_start until the result is captured.
- WAIT:
  - Capture on the first cycle disk_done=1; push {x, y, k, last = (remaining==1)}.
  - k increments modulo 2^K_WIDTH (0xFFFFFFFF wraps to 0) and remaining decrements.
  - remaining==0: go to DRAIN; otherwise go to ISSUE.
  - disk_done held high across cycles is captured once.
  - disk_done outside WAIT is ignored.
- Flow control: at most one disk operation is outstanding. The free-slot check guarantees a push never overflows, so no data is lost; backpressure only stalls issuing.
- FIFO:
  - m_valid = !empty. Head fields are stable while m_valid && !m_ready.
  - A pop occurs on m_valid && m_ready.
  - Same-cycle push and pop when full is legal: occupancy unchanged, order preserved.
  - A push into an empty FIFO appears on m_valid the next cycle (1-cycle capture latency).
- DRAIN: wait for FIFO empty, then pulse run_done and go to IDLE with busy=0.
  - For count==0, run_done fires 1 cycle after entering DRAIN.
- run_abort:
  - Accepted while busy.
  - In ISSUE: go to ABORT immediately.
  - In WAIT: the outstanding result is discarded when disk_done arrives.
  - In DRAIN, and on entering ABORT: FIFO flushed (m_valid=0 next cycle).
  - ABORT pulses run_done, clears busy, returns to IDLE.
  - Abort and run_start in the same cycle: abort wins, start ignored.
- run_start while busy is ignored.

Test Plan:
- Behavioural disk stub (ready/done latency 5, x = k<<4, y = ~k), k_start=1, count=3, bases 0/1, m_ready=1 -> stream k=1,2,3; x=0x10,0x20,0x30; y=0xFFFFFFFE,0xFFFFFFFD,0xFFFFFFFC; m_last only on k=3; one run_done pulse after the third pop.
- m_ready=0, FIFO_DEPTH=4, count=6 -> exactly 4 disk_start pulses and issuing stalls. Releasing m_ready yields 6 in-order entries with no loss or duplicates.
- k_start=0xFFFFFFFF, count=2 -> m_k = 0xFFFFFFFF then 0x00000000, with m_last on the second.
- count=0 -> no disk_start, m_valid never set, run_done pulses, busy clears.
- run_abort during WAIT with 2 entries buffered -> late disk_done is ignored, FIFO flushed, one run_done pulse, busy=0; a following run_start is accepted.
- Stub holding disk_done for 3 cycles, plus rst_n asserted mid-run -> single push per op; on reset all outputs 0 and FIFO empty.

Source files
------------

// File: rtl/disk_stream_ctrl.sv
// Run sequencer around the disk point generator: issues consecutive indices k,
// buffers each (x, y) result in a small FIFO and streams it out tagged with k/last.
module disk_stream_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int K_WIDTH    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_start,
  input  logic               run_abort,
  input  logic [K_WIDTH-1:0] k_start,
  input  logic [K_WIDTH-1:0] count,
  input  logic [1:0]         base_sel0,
  input  logic [1:0]         base_sel1,
  output logic               busy,
  output logic               run_done,
  output logic               disk_start,
  output logic [31:0]        disk_k,
  output logic [1:0]         disk_base_sel0,
  output logic [1:0]         disk_base_sel1,
  input  logic [31:0]        disk_result_x,
  input  logic [31:0]        disk_result_y,
  input  logic               disk_done,
  input  logic               disk_ready,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [31:0]        m_x,
  output logic [31:0]        m_y,
  output logic [K_WIDTH-1:0] m_k,
  output logic               m_last
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_ABORT} state_t;

  state_t             r_state, w_state_next;
  logic [K_WIDTH-1:0] r_k, r_remaining;
  logic [1:0]         r_sel0, r_sel1;
  logic               r_disk_start, r_run_done, r_armed;
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [AW:0]        r_occ;

  logic [31:0]        r_mem_x [FIFO_DEPTH];
  logic [31:0]        r_mem_y [FIFO_DEPTH];
  logic [K_WIDTH-1:0] r_mem_k [FIFO_DEPTH];
  logic               r_mem_last [FIFO_DEPTH];

  logic w_accept, w_abort, w_issue, w_capture, w_pop, w_done_next;

  assign w_accept  = (r_state == S_IDLE) && run_start && !run_abort;
  assign w_abort   = run_abort && (r_state != S_IDLE) && (r_state != S_ABORT);
  assign w_issue   = (r_state == S_ISSUE) && !run_abort && disk_ready && (r_occ < DEPTH_C);
  // r_armed requires disk_done to have been low since the start, so a done level
  // left over from the previous operation is never captured twice.
  assign w_capture = (r_state == S_WAIT) && !run_abort && disk_done && r_armed;
  assign w_pop     = m_valid && m_ready;

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE:
        if (w_accept) w_state_next = (count == '0) ? S_DRAIN : S_ISSUE;
      S_ISSUE:
        if (w_abort) w_state_next = S_ABORT;
        else if (w_issue) w_state_next = S_WAIT;
      S_WAIT:
        if (w_abort) w_state_next = S_ABORT;
        else if (w_capture) w_state_next = (r_remaining == K_WIDTH'(1)) ? S_DRAIN : S_ISSUE;
      S_DRAIN:
        if (w_abort) w_state_next = S_ABORT;
        else if (r_occ == '0) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      S_ABORT: begin
        w_state_next = S_IDLE;
        w_done_next  = 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_remaining  <= '0;
      r_sel0       <= '0;
      r_sel1       <= '0;
      r_disk_start <= 1'b0;
      r_run_done   <= 1'b0;
      r_armed      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_disk_start <= w_issue;
      r_run_done   <= w_done_next;
      if (w_accept) begin
        r_k         <= k_start;
        r_remaining <= count;
        r_sel0      <= base_sel0;
        r_sel1      <= base_sel1;
      end else if (w_capture) begin
        r_k         <= r_k + K_WIDTH'(1);
        r_remaining <= r_remaining - K_WIDTH'(1);
      end
      if (w_issue) r_armed <= !disk_done;
      else if ((r_state == S_WAIT) && !disk_done) r_armed <= 1'b1;
    end
  end

  // Abort flushes by collapsing the read pointer onto the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else if (w_abort) begin
      r_rd_ptr <= r_wr_ptr;
      r_occ    <= '0;
    end else begin
      if (w_capture) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_capture, w_pop})
        2'b10:   r_occ <= r_occ + (AW+1)'(1);
        2'b01:   r_occ <= r_occ - (AW+1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem_x[r_wr_ptr]    <= disk_result_x;
      r_mem_y[r_wr_ptr]    <= disk_result_y;
      r_mem_k[r_wr_ptr]    <= r_k;
      r_mem_last[r_wr_ptr] <= (r_remaining == K_WIDTH'(1));
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign run_done       = r_run_done;
  assign disk_start     = r_disk_start;
  assign disk_k         = 32'(r_k);
  assign disk_base_sel0 = r_sel0;
  assign disk_base_sel1 = r_sel1;
  assign m_valid        = (r_occ != '0);
  // Head fields are gated so the stream outputs read zero whenever the FIFO is empty.
  assign m_x            = m_valid ? r_mem_x[r_rd_ptr] : '0;
  assign m_y            = m_valid ? r_mem_y[r_rd_ptr] : '0;
  assign m_k            = m_valid ? r_mem_k[r_rd_ptr] : '0;
  assign m_last         = m_valid ? r_mem_last[r_rd_ptr] : 1'b0;

endmodule

// File: tb/tb_disk_stream_ctrl.sv
// Randomized bench for disk_stream_ctrl: behavioural disk stub plus a queue-based
// model of the expected stream (k, k<<4, ~k, last) per run.
module tb_disk_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_start = 1'b0, run_abort = 1'b0;
  logic [31:0] k_start = '0, count = '0;
  logic [1:0]  base_sel0 = '0, base_sel1 = '0;
  logic        busy, run_done, disk_start;
  logic [31:0] disk_k;
  logic [1:0]  disk_base_sel0, disk_base_sel1;
  logic [31:0] disk_result_x, disk_result_y;
  logic        disk_done, disk_ready;
  logic        m_valid, m_ready = 1'b0;
  logic [31:0] m_x, m_y, m_k;
  logic        m_last;

  always #5 clk = ~clk;

  disk_stream_ctrl #(.FIFO_DEPTH(4), .K_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .run_start(run_start), .run_abort(run_abort),
    .k_start(k_start), .count(count), .base_sel0(base_sel0), .base_sel1(base_sel1),
    .busy(busy), .run_done(run_done), .disk_start(disk_start), .disk_k(disk_k),
    .disk_base_sel0(disk_base_sel0), .disk_base_sel1(disk_base_sel1),
    .disk_result_x(disk_result_x), .disk_result_y(disk_result_y),
    .disk_done(disk_done), .disk_ready(disk_ready),
    .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y), .m_k(m_k), .m_last(m_last)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Disk stub: result latency and done-hold length are adjustable per test.
  logic [31:0] sk;
  int lat = 5, hold_cycles = 1, scnt, shold;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disk_ready <= 1'b1; disk_done <= 1'b0; scnt <= 0; shold <= 0;
      disk_result_x <= '0; disk_result_y <= '0; sk <= '0;
    end else if (disk_start) begin
      disk_ready <= 1'b0; disk_done <= 1'b0; sk <= disk_k; scnt <= lat; shold <= 0;
    end else if (scnt > 0) begin
      scnt <= scnt - 1;
      if (scnt == 1) begin
        disk_done <= 1'b1; disk_ready <= 1'b1;
        disk_result_x <= sk << 4; disk_result_y <= ~sk; shold <= hold_cycles;
      end
    end else if (shold > 0) begin
      shold <= shold - 1;
      if (shold == 1) disk_done <= 1'b0;
    end
  end

  int rdy_mode = 0;  // 0: hold off, 1: always ready, 2: random
  always @(posedge clk) begin
    #1;
    m_ready = (rdy_mode == 1) || ((rdy_mode == 2) && ($urandom_range(0, 1) == 1));
  end

  typedef struct {logic [31:0] k, x, y; logic last;} ent_t;
  ent_t exp_q[$];
  ent_t e;
  int start_cnt = 0, done_cnt = 0, pop_cnt = 0;
  bit vseen = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (disk_start) start_cnt++;
      if (run_done) done_cnt++;
      if (m_valid) vseen = 1;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("extra_pop", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          chk("m_k", 64'(m_k), 64'(e.k));
          chk("m_x", 64'(m_x), 64'(e.x));
          chk("m_y", 64'(m_y), 64'(e.y));
          chk("m_last", 64'(m_last), 64'(e.last));
          $display("pop k=%08h x=%08h y=%08h last=%0d", m_k, m_x, m_y, m_last);
          pop_cnt++;
        end
      end
    end
  end

  task automatic do_run(input logic [31:0] ks, input logic [31:0] cn, input logic [1:0] s0, input logic [1:0] s1);
    logic [31:0] kk;
    for (int i = 0; i < int'(cn); i++) begin
      kk = ks + 32'(i);
      exp_q.push_back('{k: kk, x: kk << 4, y: ~kk, last: (i == int'(cn) - 1)});
    end
    k_start = ks; count = cn; base_sel0 = s0; base_sel1 = s1; run_start = 1'b1;
    @(posedge clk); #1 run_start = 1'b0;
    $display("run k_start=%08h count=%0d", ks, cn);
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit got = 0;
    for (int n = 0; n < budget && !got; n++) begin
      @(negedge clk);
      if (run_done) got = 1;
    end
    chk(tag, 64'(got), 64'(1));
    @(posedge clk); #1;
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_left"}, 64'(exp_q.size()), 64'(0));
  endtask

  int sb, db, pb, cn_r;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_valid", 64'(m_valid), 64'(0));
    chk("rst_start", 64'(disk_start), 64'(0));
    chk("rst_done", 64'(run_done), 64'(0));
    chk("rst_outs", {m_x, disk_k}, 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Basic run: k=1..3, sels latched at start
    rdy_mode = 1; lat = 5; sb = start_cnt; db = done_cnt; pb = pop_cnt;
    do_run(32'd1, 32'd3, 2'd0, 2'd1);
    base_sel0 = 2'd3; base_sel1 = 2'd3;
    @(negedge clk);
    chk("sel0_latched", 64'(disk_base_sel0), 64'(0));
    chk("sel1_latched", 64'(disk_base_sel1), 64'(1));
    chk("busy_in_run", 64'(busy), 64'(1));
    wait_done(200, "basic_done");
    chk("basic_pops", 64'(pop_cnt - pb), 64'(3));
    chk("basic_done_cnt", 64'(done_cnt - db), 64'(1));

    // Backpressure: only FIFO_DEPTH operations may be issued
    rdy_mode = 0; sb = start_cnt; pb = pop_cnt;
    do_run(32'h100, 32'd6, 2'd2, 2'd3);
    repeat (80) @(posedge clk);
    @(negedge clk);
    chk("bp_starts", 64'(start_cnt - sb), 64'(4));
    chk("bp_valid", 64'(m_valid), 64'(1));
    @(posedge clk); #1 rdy_mode = 1;
    wait_done(300, "bp_done");
    chk("bp_pops", 64'(pop_cnt - pb), 64'(6));
    chk("bp_starts_total", 64'(start_cnt - sb), 64'(6));

    // Index wrap
    pb = pop_cnt;
    do_run(32'hFFFF_FFFF, 32'd2, 2'd1, 2'd0);
    wait_done(200, "wrap_done");
    chk("wrap_pops", 64'(pop_cnt - pb), 64'(2));

    // Empty run
    sb = start_cnt; db = done_cnt; vseen = 0;
    do_run(32'd7, 32'd0, 2'd0, 2'd0);
    wait_done(4, "zero_done");
    chk("zero_starts", 64'(start_cnt - sb), 64'(0));
    chk("zero_valid_seen", 64'(vseen), 64'(0));
    chk("zero_done_cnt", 64'(done_cnt - db), 64'(1));

    // Abort during WAIT with two entries buffered
    rdy_mode = 0; sb = start_cnt;
    do_run(32'h200, 32'd5, 2'd0, 2'd0);
    for (int n = 0; n < 200 && start_cnt - sb < 3; n++) @(negedge clk);
    chk("ab_third_start", 64'(start_cnt - sb), 64'(3));
    @(posedge clk); #1 run_abort = 1'b1;
    exp_q.delete();
    db = done_cnt;
    @(posedge clk); #1 run_abort = 1'b0;
    @(negedge clk);
    chk("ab_flushed", 64'(m_valid), 64'(0));
    wait_done(10, "ab_done");
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("ab_late_valid", 64'(m_valid), 64'(0));
    chk("ab_done_cnt", 64'(done_cnt - db), 64'(1));
    @(posedge clk); #1 rdy_mode = 1; pb = pop_cnt;
    do_run(32'h300, 32'd2, 2'd1, 2'd1);
    wait_done(200, "post_ab_done");
    chk("post_ab_pops", 64'(pop_cnt - pb), 64'(2));

    // disk_done held three cycles: one push per operation
    hold_cycles = 3; sb = start_cnt; pb = pop_cnt;
    do_run(32'h400, 32'd4, 2'd0, 2'd0);
    wait_done(300, "hold_done");
    chk("hold_pops", 64'(pop_cnt - pb), 64'(4));
    chk("hold_starts", 64'(start_cnt - sb), 64'(4));

    // Reset mid-run
    do_run(32'h500, 32'd5, 2'd2, 2'd3);
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    db = done_cnt;
    chk("mr_busy", 64'(busy), 64'(0));
    chk("mr_valid", 64'(m_valid), 64'(0));
    chk("mr_ctl", {60'd0, disk_start, run_done, m_last, |disk_base_sel0}, 64'(0));
    chk("mr_data", {m_x | m_y | m_k, disk_k}, 64'(0));
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("mr_no_done", 64'(done_cnt - db), 64'(0));
    chk("mr_idle", 64'(busy), 64'(0));
    @(posedge clk); #1;

    // Random runs against the model
    for (int r = 0; r < 10; r++) begin
      rdy_mode = 2; lat = $urandom_range(1, 6); hold_cycles = $urandom_range(1, 3);
      cn_r = $urandom_range(0, 7); sb = start_cnt; pb = pop_cnt;
      do_run($urandom, 32'(cn_r), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      wait_done(1000, "rnd_done");
      chk("rnd_pops", 64'(pop_cnt - pb), 64'(cn_r));
      chk("rnd_starts", 64'(start_cnt - sb), 64'(cn_r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
